// File: rtl/lsu_ctrl_pkg.sv
// Shared constants and types for the load/store unit: bus width, access size encodings
// and the alignment rule used by the controller.
package lsu_ctrl_pkg;

  localparam int unsigned BusW = 32;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeBad  = 2'b11
  } size_e;

  // Size 11 is treated as misaligned so it takes the same error path.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SizeByte: bad = 1'b0;
      SizeHalf: bad = addr_lo[0];
      SizeWord: bad = (addr_lo != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response channel of the load/store unit.
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [31:0]     req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [BusW-1:0] req_wdata;
  logic            resp_valid;
  logic [BusW-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, merges sub-word store data
// into the word read back from memory.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  size_e           size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  input  logic [BusW-1:0] rdata,
  input  logic [15:0]     wdata,
  output logic [BusW-1:0] load_data,
  output logic [BusW-1:0] store_data
);

  logic [BusW-1:0] shifted;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = shifted[15:0];

    load_data = rdata;
    case (size)
      SizeByte: load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      SizeHalf: load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
      default:  load_data = rdata;
    endcase

    store_data = rdata;
    case (size)
      SizeByte: store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SizeHalf: store_data[{addr_lo[1], 4'b0000} +: 16] = wdata;
      default:  store_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for a word-wide BRAM with one-cycle registered reads.
// Sub-word stores do a read-modify-write; misaligned requests respond with an error.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  lsu_ctrl_if.slave       core,
  output logic [31:2]     mem_addr,
  output logic            mem_we,
  output logic [BusW-1:0] mem_wdata,
  input  logic [BusW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StLd   = 3'd2,
    StWr   = 3'd3,
    StErr  = 3'd4
  } state_e;

  state_e          state_q;
  logic [31:0]     addr_q;
  size_e           size_q;
  logic            we_q;
  logic            uns_q;
  logic [BusW-1:0] wdata_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic            mem_we_q;

  logic            accept;
  size_e           req_size;
  logic [BusW-1:0] load_data;
  logic [BusW-1:0] store_data;

  assign req_size = size_e'(core.req_size);
  assign accept   = core.req_valid && core.req_ready;

  // Response and write strobes are set on the transition into LD/WR/ERR so they
  // leave the FSM as registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      size_q       <= SizeByte;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= core.req_addr;
            size_q  <= req_size;
            we_q    <= core.req_we;
            uns_q   <= core.req_unsigned;
            wdata_q <= core.req_wdata;
            if (is_misaligned(req_size, core.req_addr[1:0])) begin
              state_q      <= StErr;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (core.req_we && req_size == SizeWord) begin
              state_q      <= StWr;
              mem_we_q     <= 1'b1;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          resp_valid_q <= 1'b1;
          if (we_q) begin
            state_q  <= StWr;
            mem_we_q <= 1'b1;
          end else begin
            state_q <= StLd;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .rdata       (mem_rdata),
    .wdata       (wdata_q[15:0]),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Reset gating is combinational so outputs are quiet in the very cycle rst rises.
  assign core.req_ready  = !rst && (state_q == StIdle);
  assign core.resp_valid = !rst && resp_valid_q;
  assign core.resp_err   = !rst && resp_err_q;
  assign core.resp_rdata = (!rst && state_q == StLd) ? load_data : '0;

  assign mem_addr  = rst ? '0 : addr_q[31:2];
  assign mem_we    = !rst && mem_we_q;
  assign mem_wdata = (state_q != StWr) ? '0 :
                     (size_q == SizeWord) ? wdata_q : store_data;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a registered-read BRAM model.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic            clk;
  logic            rst;
  logic [31:2]     mem_addr;
  logic            mem_we;
  logic [BusW-1:0] mem_wdata;
  logic [BusW-1:0] mem_rdata;
  logic [31:0]     mem [0:255];
  int              n_cmp;
  int              n_bad;
  int              we_total;
  int              rv_total;

  lsu_ctrl_if bus ();

  lsu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .core      (bus.slave),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr[9:2]];
  always @(negedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  always @(negedge clk) if (mem_we) we_total <= we_total + 1;
  always @(negedge clk) if (bus.resp_valid) rv_total <= rv_total + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  // Issues one request; reports latency (1 = T+1), response data, and write strobes.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int we_cnt, output int we_at, output int rv_cnt);
    int w;
    @(posedge clk); #1;
    set_req(we, addr, size, uns, wdata);
    bus.req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 99; rdata = 'x; err = 1'bx; we_cnt = 0; we_at = 0; rv_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        if (we_at == 0) we_at = c;
      end
      if (bus.resp_valid) begin
        rv_cnt++;
        if (lat == 99) begin
          lat   = c;
          rdata = bus.resp_rdata;
          err   = bus.resp_err;
        end
      end
    end
  endtask

  int          lat, we_cnt, we_at, rv_cnt, we_snap, rv_snap;
  logic [31:0] rdata;
  logic        err;

  initial begin
    n_cmp = 0; n_bad = 0; we_total = 0; rv_total = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'h8899AABB;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    set_req(1'b0, 32'd0, 2'b00, 1'b0, 32'd0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rv", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {2'b00, mem_addr}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // Signed / unsigned byte loads from the top lane
    do_req("lb", 1'b0, 32'h103, 2'b00, 1'b0, 32'd0, lat, rdata, err, we_cnt, we_at, rv_cnt);
    chk("lb_lat", lat, 2);
    chk("lb_data", rdata, 32'hFFFFFF88);
    chk("lb_err", {31'd0, err}, 32'd0);
    chk("lb_rvcnt", rv_cnt, 1);
    do_req("lbu", 1'b0, 32'h103, 2'b00, 1'b1, 32'd0, lat, rdata, err, we_cnt, we_at, rv_cnt);
    chk("lbu_lat", lat, 2);
    chk("lbu_data", rdata, 32'h00000088);
    do_req("lh", 1'b0, 32'h100, 2'b01, 1'b0, 32'd0, lat, rdata, err, we_cnt, we_at, rv_cnt);
    chk("lh_data", rdata, 32'hFFFFAABB);

    // Reset during RD of a byte store aborts it
    we_snap = we_total; rv_snap = rv_total;
    @(posedge clk); #1;
    set_req(1'b1, 32'h100, 2'b00, 1'b0, 32'h55);
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("rs_accept_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rs_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    chk("rs_addr_in_rst", {2'b00, mem_addr}, 32'd0);
    chk("rs_we_in_rst", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rs_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rs_no_write", we_total - we_snap, 0);
    chk("rs_no_resp", rv_total - rv_snap, 0);
    do_req("rs_lw", 1'b0, 32'h100, 2'b10, 1'b0, 32'd0, lat, rdata, err, we_cnt, we_at, rv_cnt);
    chk("rs_lw_data", rdata, 32'h8899AABB);

    // Half store into the upper lane (read-modify-write)
    do_req("sh", 1'b1, 32'h102, 2'b01, 1'b0, 32'h00001234, lat, rdata, err, we_cnt, we_at,
           rv_cnt);
    chk("sh_lat", lat, 2);
    chk("sh_we_at", we_at, 2);
    chk("sh_we_cnt", we_cnt, 1);
    chk("sh_rdata", rdata, 32'd0);
    chk("sh_mem", mem[8'h40], 32'h1234AABB);
    do_req("sh_lw", 1'b0, 32'h100, 2'b10, 1'b0, 32'd0, lat, rdata, err, we_cnt, we_at, rv_cnt);
    chk("sh_lw_data", rdata, 32'h1234AABB);

    // Word store
    do_req("sw", 1'b1, 32'h104, 2'b10, 1'b0, 32'hDEADBEEF, lat, rdata, err, we_cnt, we_at,
           rv_cnt);
    chk("sw_lat", lat, 1);
    chk("sw_we_at", we_at, 1);
    chk("sw_we_cnt", we_cnt, 1);
    chk("sw_err", {31'd0, err}, 32'd0);
    do_req("sw_lw", 1'b0, 32'h104, 2'b10, 1'b0, 32'd0, lat, rdata, err, we_cnt, we_at, rv_cnt);
    chk("sw_lw_data", rdata, 32'hDEADBEEF);

    // Misaligned and illegal-size requests
    do_req("mis_lw", 1'b0, 32'h101, 2'b10, 1'b0, 32'd0, lat, rdata, err, we_cnt, we_at, rv_cnt);
    chk("mis_lw_lat", lat, 1);
    chk("mis_lw_err", {31'd0, err}, 32'd1);
    chk("mis_lw_data", rdata, 32'd0);
    do_req("bad_sz", 1'b1, 32'h100, 2'b11, 1'b0, 32'hCAFEF00D, lat, rdata, err, we_cnt, we_at,
           rv_cnt);
    chk("bad_sz_lat", lat, 1);
    chk("bad_sz_err", {31'd0, err}, 32'd1);
    chk("bad_sz_data", rdata, 32'd0);
    chk("bad_sz_we", we_cnt, 0);
    chk("bad_sz_mem", mem[8'h40], 32'h1234AABB);

    // Back-to-back loads with req_valid held high
    @(posedge clk); #1;
    set_req(1'b0, 32'h104, 2'b10, 1'b0, 32'd0);
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready0", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    set_req(1'b0, 32'h101, 2'b00, 1'b0, 32'd0);
    @(negedge clk);
    chk("b2b_busy_rd", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_rv1", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_data1", bus.resp_rdata, 32'hDEADBEEF);
    chk("b2b_busy_ld", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready1", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_rv_gap", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy2", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_rv2", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_data2", bus.resp_rdata, 32'hFFFFFFAA);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  core load/store request present.
REQ-004 req_ready  output  1  block accepts a request this cycle.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_wdata  input  `BUS  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 resp_rdata  output  `BUS  extended load data; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned or illegal request, valid with resp_valid.
REQ-013 mem_addr  output  [31:2]  word address to the word-wide BRAM.
REQ-014 mem_we  output  1  BRAM write enable; BRAM commits on negedge of the same cycle.
REQ-015 mem_wdata  output  `BUS  full-word BRAM write data.
REQ-016 mem_rdata  input  `BUS  BRAM read data, registered: valid the cycle after mem_addr is presented.

Function
REQ-017 FSM states: IDLE, RD, LD, WR, ERR.
REQ-018 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted on req_valid && req_ready.
REQ-019 On accept, addr/size/we/unsigned/wdata SHALL be captured into registers; mem_addr SHALL come from the captured address.
REQ-020 Misaligned SHALL mean: half with addr[0]=1, word with addr[1:0]!=00, or size 11.
REQ-021 Transitions: accepted misaligned -> ERR; aligned load or sub-word store -> RD; aligned word store -> WR.
REQ-022 RD -> LD for a load, RD -> WR for a sub-word store.
REQ-023 LD, WR and ERR -> IDLE unconditionally.
REQ-024 mem_we SHALL be 1 only in WR and SHALL be forced to 0 in any cycle where rst is high.
REQ-025 In WR, mem_wdata SHALL be the captured wdata for word stores.
REQ-026 In WR for sub-word stores, mem_wdata SHALL be mem_rdata with the selected little-endian byte or half lane replaced by wdata[7:0] or wdata[15:0].
REQ-027 resp_valid SHALL be 1 for exactly one cycle in each of LD, WR and ERR.
REQ-028 resp_err SHALL be 1 only in ERR.
REQ-029 In LD, resp_rdata SHALL be the addressed lane of mem_rdata, extended per req_unsigned.
REQ-030 Latency from the accept cycle T: word store T+1; misaligned T+1; load T+2; sub-word store T+2.
REQ-031 A new request SHALL be accepted no earlier than the cycle after resp_valid.
REQ-032 An ERR request SHALL perform no memory write.

Reset
REQ-033 rst high SHALL force state to IDLE and clear captured registers.
REQ-034 While rst is high, outputs SHALL be: resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, req_ready=0.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no response and no write; req_ready=1 the first cycle after rst falls.

Structure
REQ-036 Size encodings (byte/half/word) SHALL be shared constants in inc/define.vh next to `BUS; FSM state encodings SHALL be local to the module.
REQ-037 Lane extraction/extension and store merging SHALL be one combinational sub-module, lsu_align.

Verification
REQ-038 Preload word 0x100 = 0x8899AABB; signed byte load at 0x103 -> resp at T+2 with 0xFFFFFF88; the same load unsigned -> 0x00000088.
REQ-039 Half store 0x00001234 at 0x102 -> mem_we high for exactly one cycle (T+2), word becomes 0x1234AABB; a following word load at 0x100 returns 0x1234AABB.
REQ-040 Word store 0xDEADBEEF at 0x104 -> mem_we and resp_valid at T+1, resp_err=0; a word load at 0x104 returns 0xDEADBEEF.
REQ-041 Word load at 0x101 and size=11 at 0x100 -> resp_valid and resp_err at T+1, resp_rdata=0, mem_we never asserted.
REQ-042 rst pulsed during RD of a byte store to 0x100 -> no mem_we, no resp_valid, word still 0x8899AABB, req_ready=1 the cycle after rst falls.
REQ-043 req_valid held high with back-to-back loads -> req_ready low while busy; the second request is accepted the cycle after the first resp_valid, and both return the correct data.
